// File: rtl/mem_pkg.sv
// Shared constants and types for the Modified Enigma Machine encoder/decoder pair.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } setting_t;

    // Rotor offsets, indexed by setting: K[0]=3, K[1]=7, K[2]=11, K[3]=19.
    localparam logic [3:0][4:0] K = {5'd19, 5'd11, 5'd7, 5'd3};

    // Setting the sequencer starts from after reset.
    localparam setting_t SETTING_RST = S10;

    localparam logic [7:0] CHAR_UC_A = 8'h41;
    localparam logic [7:0] CHAR_UC_Z = 8'h5A;
    localparam logic [7:0] CHAR_LC_A = 8'h61;
    localparam logic [7:0] CHAR_LC_Z = 8'h7A;

    // Step order shared with the encoder: 10 -> 01 -> 00 -> 11 -> 10.
    function automatic setting_t next_setting(input setting_t s);
        case (s)
            S10:     return S01;
            S01:     return S00;
            S00:     return S11;
            default: return S10;
        endcase
    endfunction

endpackage

// File: rtl/mem_decoder_if.sv
// Ciphertext-in / plaintext-out stream bundle for the MEM decoder.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the input and output streams.
interface mem_decoder_if;
    import mem_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    setting_t   out_setting;

    // Decoder side of the bundle.
    modport slave (
        input  in_valid, in_char, out_ready,
        output in_ready, out_valid, out_char, out_setting
    );

    // Source/consumer side of the bundle.
    modport master (
        output in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_char, out_setting
    );
endinterface

// File: rtl/mem_dec_core.sv
// Combinational letter decoder: (cipher char, setting) -> (plain char, is_letter).
// Latency: zero cycles (pure combinational).
// Backpressure: none; lowercase handling gated by MEM_DEC_LOWERCASE_EN.
module mem_dec_core
    import mem_pkg::*;
(
    input  logic [7:0] char_in,
    input  setting_t   setting,
    output logic [7:0] char_out,
    output logic       is_letter
);

    logic [7:0] base;
    logic [5:0] idx;
    logic [5:0] off;
    logic [5:0] diff;

    // Classify the character, then subtract the offset with a single +26 fix-up.
    always_comb begin
        is_letter = 1'b0;
        base      = CHAR_UC_A;
        if (char_in >= CHAR_UC_A && char_in <= CHAR_UC_Z) begin
            is_letter = 1'b1;
            base      = CHAR_UC_A;
        end
`ifdef MEM_DEC_LOWERCASE_EN
        else if (char_in >= CHAR_LC_A && char_in <= CHAR_LC_Z) begin
            is_letter = 1'b1;
            base      = CHAR_LC_A;
        end
`endif
        idx  = 6'(char_in - base);
        off  = {1'b0, K[setting]};
        diff = idx - off;
        if (idx < off) begin
            diff = diff + 6'd26;
        end
        char_out = is_letter ? (base + {2'b00, diff}) : char_in;
    end

endmodule

// File: rtl/mem_decoder.sv
// MEM streaming decoder: setting sequencer, input handshake and one output register.
// Latency: one cycle from accept to out_valid; full throughput with out_ready held high.
// Backpressure: in_ready = !load && (!out_valid || out_ready). Optional: MEM_DEC_LOWERCASE_EN.
module mem_decoder
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mem_decoder_if.slave     bus,
    input  logic             load,
    input  setting_t         load_setting,
    output setting_t         cur_setting
);

    setting_t   cur_q, cur_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_char_q, out_char_d;
    setting_t   out_setting_q, out_setting_d;

    logic [7:0] plain_char;
    logic       is_letter;
    logic       accept;

    mem_dec_core u_core (
        .char_in   (bus.in_char),
        .setting   (cur_q),
        .char_out  (plain_char),
        .is_letter (is_letter)
    );

    // Handshake, sequencer step and output-stage next state.
    always_comb begin
        bus.in_ready  = !load && (!out_valid_q || bus.out_ready);
        accept        = bus.in_valid && bus.in_ready;

        cur_d         = cur_q;
        out_valid_d   = out_valid_q && !bus.out_ready;
        out_char_d    = out_char_q;
        out_setting_d = out_setting_q;

        // load and accept are mutually exclusive because in_ready is low during load.
        if (load) begin
            cur_d = load_setting;
        end else if (accept && is_letter) begin
            cur_d = next_setting(cur_q);
        end

        if (accept) begin
            out_valid_d   = 1'b1;
            out_char_d    = plain_char;
            out_setting_d = cur_q;
        end
    end

    // State register; synchronous reset discards any held output character.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q         <= SETTING_RST;
            out_valid_q   <= 1'b0;
            out_char_q    <= 8'h00;
            out_setting_q <= SETTING_RST;
        end else begin
            cur_q         <= cur_d;
            out_valid_q   <= out_valid_d;
            out_char_q    <= out_char_d;
            out_setting_q <= out_setting_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_char    = out_char_q;
    assign bus.out_setting = out_setting_q;
    assign cur_setting     = cur_q;

endmodule

// File: doc/mem_decoder.md
# mem_decoder

Streaming decryption engine for the Modified Enigma Machine: the receive-side inverse of the MEM encoder. It accepts ciphertext characters over a valid/ready handshake and subtracts the rotor offset selected by an internal setting sequencer. It emits plaintext from a registered output stage. It sits between the ciphertext source (UART/host FIFO) and the plaintext consumer, and uses the same setting stepping order as the encoder so the two stay in lockstep.

## Interface
- No parameters; all constants live in the shared package.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  one-cycle pulse: load `load_setting` into the sequencer.
- load_setting  in  2  initial rotor setting.
- in_valid  in  1  ciphertext character valid.
- in_ready  out  1  decoder can accept a character this cycle.
- in_char  in  8  ciphertext ASCII character.
- out_valid  out  1  plaintext character valid.
- out_ready  in  1  consumer accepts the character this cycle.
- out_char  out  8  plaintext ASCII character.
- out_setting  out  2  setting used to decode `out_char`.
- cur_setting  out  2  setting that will decode the next letter.

## Operation
- Cipher definition, fixed by the encoder: letter index i = char − 'A' for 'A'..'Z'; encoder c = (p + K[s]) mod 26.
- Offsets: K[00]=3, K[01]=7, K[10]=11, K[11]=19.
- Decoder computes p = (c − K[s] + 26) mod 26 and returns 'A' + p.
  - Arithmetic is done in 6 bits unsigned; one conditional +26 correction; no divider.
- Non-letters (every code outside 'A'..'Z', subject to Configuration) pass through unchanged and do not advance the setting.
- Sequencer steps once per accepted letter in this order: 10 → 01 → 00 → 11 → 10.
- Accept happens when in_valid && in_ready. On accept, the decoded character and the setting it used are registered into the output stage.

## Timing
- Reset values: out_valid=0, out_char=8'h00, out_setting=2'b10, cur_setting=2'b10. in_ready goes to 1 in the first cycle after reset is released.
- Latency: one cycle. A character accepted at edge N is presented on out_char at edge N with out_valid=1.
- Single output register. in_ready = !load && (!out_valid || out_ready).
  - This gives full throughput of one character per cycle under continuous out_ready.
- Output-stage behaviour:
  - out_valid && !out_ready: out_char, out_setting and out_valid hold stable, and in_ready=0.
  - Output drains with no new accept: out_valid clears on that edge.
- load: cur_setting ← load_setting on that edge. in_ready is forced to 0 in the load cycle, so load never coincides with an accept. A pending output character is unaffected.
- rst_n low mid-stream: all state returns to reset values on that edge and any held output character is discarded. rst_n has priority over load.
- Back-to-back letters use successive settings with no gaps. Interleaved non-letters do not consume a setting.

## Configuration
- MEM_DEC_LOWERCASE_EN defined: 'a'..'z' are decoded with the same offsets, case is preserved, and each lowercase letter advances the sequencer.
- Not defined: lowercase characters are non-letters, meaning they pass through unchanged with no step.

## Structure
- Shared package `mem_pkg` holds:
  - the setting typedef (2-bit enum S00/S01/S10/S11);
  - the offset constant table K;
  - the `next_setting` function defining the step order;
  - the reset setting constant S10.
  - The encoder uses the same package.
- Sub-module `mem_dec_core` is purely combinational: (char, setting) → (plain char, is_letter).
- The top level holds the sequencer, the handshake and the output register.

## Test plan
- Reset, then stream "SLOE" with out_ready=1 → out "HELL", out_setting 10,01,00,11, then cur_setting=10.
- Wrap-around: load 11, send 'A' → 'H' (0−19+26=7). Load 00, send 'Z' → 'W'.
- Send "S L" (space between letters) from reset → "H E" plus the space; cur_setting=00 afterwards (space consumed no step).
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_char stable; on release, the next character is accepted with no loss or duplication.
- load=1 together with in_valid=1 → no accept that cycle. Next accept uses load_setting.
- Assert rst_n=0 while out_valid=1 → out_valid=0, cur_setting=10 on the next edge.
- MEM_DEC_LOWERCASE_EN build: from reset, 's' → 'h' and cur_setting→01. Without the macro: 's' → 's' and cur_setting stays 10.
